// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default timing constants, parity helper.
// Also imported by the mouse receive path, so both directions compute parity the same way.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RTS,
      ST_REQ,
      ST_DATA,
      ST_STOP,
      ST_ACK,
      ST_WAITI
   } ps2_state_e;

   localparam int RTS_CYCLES_DEF     = 5000;
   localparam int TIMEOUT_CYCLES_DEF = 1000000;
   localparam int FILTER_LEN_DEF     = 8;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher: output flips only after FILTER_LEN equal samples; o_fall pulses for one cycle on 1->0.
// Fall is flagged combinationally in the cycle the shift register fills with zeros; no backpressure.
module ps2_clk_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = FILTER_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_ps2c,
   output logic o_fall
);

   logic [FILTER_LEN-1:0] r_sr;
   logic                  r_f;
   logic [FILTER_LEN-1:0] w_sr_nxt;
   logic                  w_f_nxt;

   assign w_sr_nxt = {r_sr[FILTER_LEN-2:0], i_ps2c};

   always_comb begin
      w_f_nxt = r_f;
      if (&w_sr_nxt)
         w_f_nxt = 1'b1;
      else if (~|w_sr_nxt)
         w_f_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sr <= '0;
         r_f  <= 1'b0;
      end else begin
         r_sr <= w_sr_nxt;
         r_f  <= w_f_nxt;
      end
   end

   assign o_fall = r_f & ~w_f_nxt;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 command transmitter (open-collector *_oe outputs, device-clocked frame, ack check).
// Ticks are registered one cycle after the deciding edge; wr_ps2 is accepted only while tx_idle=1, never queued.
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       tx_err_tick
);

   localparam int CW = $clog2(RTS_CYCLES + FILTER_LEN + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   ps2_state_e     r_state, w_state;
   logic [8:0]     r_b, w_b;
   logic [3:0]     r_n, w_n;
   logic [CW-1:0]  r_cnt, w_cnt;
   logic [WW-1:0]  r_wd, w_wd;
   logic           r_done, w_done;
   logic           r_err, w_err;
   logic           w_fall;
   logic           w_wd_on;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk    (clk),
      .reset  (reset),
      .i_ps2c (ps2c_in),
      .o_fall (w_fall)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_b     <= '0;
         r_n     <= '0;
         r_cnt   <= '0;
         r_wd    <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_b     <= w_b;
         r_n     <= w_n;
         r_cnt   <= w_cnt;
         r_wd    <= w_wd;
         r_done  <= w_done;
         r_err   <= w_err;
      end
   end

   always_comb begin
      w_state = r_state;
      w_b     = r_b;
      w_n     = r_n;
      w_cnt   = r_cnt;
      w_wd    = r_wd;
      w_done  = 1'b0;
      w_err   = 1'b0;
      w_wd_on = r_state inside {ST_REQ, ST_DATA, ST_STOP, ST_ACK, ST_WAITI};
      ps2c_oe = 1'b0;
      ps2d_oe = 1'b0;
      tx_idle = 1'b0;

      case (r_state)
         ST_IDLE: begin
            tx_idle = 1'b1;
            if (wr_ps2) begin
               w_b     = {odd_parity(din), din};
               w_cnt   = CW'(RTS_CYCLES - 1);
               w_state = ST_RTS;
            end
         end
         ST_RTS: begin
            ps2c_oe = 1'b1;
            if (r_cnt == '0) begin
               w_wd    = '0;
               w_state = ST_REQ;
            end else begin
               w_cnt = r_cnt - CW'(1);
            end
         end
         ST_REQ: begin
            ps2d_oe = 1'b1;
            if (w_fall) begin
               w_n     = '0;
               w_state = ST_DATA;
            end
         end
         ST_DATA: begin
            ps2d_oe = ~r_b[0];
            if (w_fall) begin
               if (r_n == 4'd8) begin
                  w_state = ST_STOP;
               end else begin
                  w_b = {1'b0, r_b[8:1]};
                  w_n = r_n + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (w_fall)
               w_state = ST_ACK;
         end
         ST_ACK: begin
            if (w_fall) begin
               w_done  = ~ps2d_in;
               w_err   = ps2d_in;
               w_cnt   = '0;
               w_state = ST_WAITI;
            end
         end
         ST_WAITI: begin
            // Both lines must be seen released long enough for the device to have let go.
            if (ps2c_in && ps2d_in) begin
               if (r_cnt == CW'(FILTER_LEN - 1))
                  w_state = ST_IDLE;
               else
                  w_cnt = r_cnt + CW'(1);
            end else begin
               w_cnt = '0;
            end
         end
         default: w_state = ST_IDLE;
      endcase

      // A device edge arriving on the expiry cycle still counts, so fall is tested first.
      if (w_wd_on) begin
         if (w_fall) begin
            w_wd = '0;
         end else if (r_wd == WW'(TIMEOUT_CYCLES - 1)) begin
            w_wd    = '0;
            w_done  = 1'b0;
            w_err   = 1'b1;
            w_state = ST_IDLE;
         end else begin
            w_wd = r_wd + WW'(1);
         end
      end
   end

   assign tx_done_tick = r_done;
   assign tx_err_tick  = r_err;

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboarded bench for ps2_tx: device BFM clocks frames out, tick monitor pops expected outcomes.
module tb_ps2_tx;

   localparam int RTS  = 50;
   localparam int TMO  = 2000;
   localparam int FLEN = 8;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_ps2 = 1'b0;
   logic [7:0] din = 8'h00;
   logic       ps2c_in, ps2d_in;
   logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick;
   logic       bfm_c_low = 1'b0;
   logic       bfm_d_low = 1'b0;
   logic       bfm_abort = 1'b0;
   int         bfm_falls = 0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int req_cyc = 0;
   bit          exp_tick_q[$];
   logic [10:0] exp_frame_q[$];

   assign ps2c_in = ~(ps2c_oe | bfm_c_low);
   assign ps2d_in = ~(ps2d_oe | bfm_d_low);

   ps2_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLEN)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_ps2       (wr_ps2),
      .din          (din),
      .ps2c_in      (ps2c_in),
      .ps2d_in      (ps2d_in),
      .ps2c_oe      (ps2c_oe),
      .ps2d_oe      (ps2d_oe),
      .tx_idle      (tx_idle),
      .tx_done_tick (tx_done_tick),
      .tx_err_tick  (tx_err_tick)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic p;
      p = (($countones(d) % 2) == 0);
      return {1'b1, p, d, 1'b0};
   endfunction

   // Tick monitor, RTS-length monitor and REQ-entry timestamp.
   int  rts_run = 0;
   logic prev_c_oe = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         rts_run   = 0;
         prev_c_oe = 1'b0;
      end else begin
         if (tx_done_tick || tx_err_tick) begin
            check("tick_exclusive", {31'd0, tx_done_tick & tx_err_tick}, 0);
            if (exp_tick_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_tick: got done=%0b err=%0b expected none", tx_done_tick, tx_err_tick);
            end else begin
               check("tick_is_err", {31'd0, tx_err_tick}, {31'd0, exp_tick_q.pop_front()});
            end
         end
         if (ps2c_oe) begin
            rts_run++;
         end else if (rts_run > 0) begin
            check("rts_len", rts_run, RTS);
            rts_run = 0;
         end
         if (prev_c_oe && !ps2c_oe && ps2d_oe) req_cyc = cyc;
         prev_c_oe = ps2c_oe;
      end
   end

   task automatic bfm_hold(input int n);
      for (int i = 0; i < n; i++) begin
         if (bfm_abort) return;
         @(negedge clk);
      end
   endtask

   // Device model: waits for REQ, reads start, clocks 11 bits out (reading on rising edges), then acks.
   task automatic bfm_run(input bit ack, input int glitch_clk, output logic [10:0] cap);
      int t;
      cap = '0;
      t = 0;
      while (!(ps2c_in && !ps2d_in) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         n_cmp++;
         n_bad++;
         $display("FAIL bfm_req_wait: got no request after %0d cycles expected REQ", t);
         return;
      end
      cap[0] = ps2d_in;
      bfm_hold(HALF);
      for (int i = 1; i <= 12; i++) begin
         if (i == 12) begin
            bfm_d_low = ack;
            bfm_hold(HALF / 2);
         end
         bfm_c_low = 1'b1;
         bfm_falls++;
         bfm_hold(HALF);
         bfm_c_low = 1'b0;
         if (i <= 10) cap[i] = ps2d_in;
         if (i == glitch_clk) begin
            bfm_hold(5);
            bfm_c_low = 1'b1;
            bfm_hold(3);
            bfm_c_low = 1'b0;
            bfm_hold(HALF - 8);
         end else begin
            bfm_hold(HALF);
         end
         if (bfm_abort) break;
      end
      bfm_hold(HALF / 2);
      bfm_d_low = 1'b0;
      bfm_c_low = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (!tx_idle && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check(name, {31'd0, tx_idle}, 1);
   endtask

   task automatic issue(input logic [7:0] d);
      wait_idle("idle_before_issue");
      din    = d;
      wr_ps2 = 1'b1;
      @(negedge clk);
      wr_ps2 = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] d, input bit ack, input int glitch, input bit poke);
      logic [10:0] cap;
      exp_frame_q.push_back(frame_of(d));
      exp_tick_q.push_back(!ack);
      issue(d);
      if (poke) begin
         repeat (10) @(negedge clk);
         check("busy_idle_low", {31'd0, tx_idle}, 0);
         din    = 8'hAA;
         wr_ps2 = 1'b1;
         @(negedge clk);
         wr_ps2 = 1'b0;
      end
      bfm_run(ack, glitch, cap);
      check("frame", {21'd0, cap}, {21'd0, exp_frame_q.pop_front()});
      wait_idle("idle_after_xfer");
      repeat (5) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected completion");
      $fatal(1);
   end

   initial begin
      logic [10:0] cap_r;
      int t;
      repeat (3) @(negedge clk);
      check("rst_c_oe", {31'd0, ps2c_oe}, 0);
      check("rst_d_oe", {31'd0, ps2d_oe}, 0);
      check("rst_idle", {31'd0, tx_idle}, 1);
      check("rst_done", {31'd0, tx_done_tick}, 0);
      check("rst_err", {31'd0, tx_err_tick}, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      xfer(8'hF4, 1'b1, 0, 1'b0);
      xfer(8'hFF, 1'b1, 0, 1'b0);
      xfer(8'h00, 1'b0, 0, 1'b0);

      // Device never clocks: watchdog must fire.
      exp_tick_q.push_back(1'b1);
      issue(8'h5A);
      t = 0;
      while (!tx_err_tick && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("tmo_delay", cyc - req_cyc, TMO);
      check("tmo_c_oe", {31'd0, ps2c_oe}, 0);
      check("tmo_d_oe", {31'd0, ps2d_oe}, 0);
      check("tmo_idle", {31'd0, tx_idle}, 1);
      repeat (5) @(negedge clk);

      // Reset while d4 is on the line.
      issue(8'hF4);
      bfm_falls = 0;
      fork
         bfm_run(1'b1, 0, cap_r);
         begin
            t = 0;
            while (bfm_falls < 5 && t < 2000) begin
               @(negedge clk);
               t++;
            end
            repeat (12) @(negedge clk);
            #2 reset = 1'b0;
            #1;
            check("rstmid_c_oe", {31'd0, ps2c_oe}, 0);
            check("rstmid_d_oe", {31'd0, ps2d_oe}, 0);
            check("rstmid_idle", {31'd0, tx_idle}, 1);
            check("rstmid_ticks", {30'd0, tx_done_tick, tx_err_tick}, 0);
            bfm_abort = 1'b1;
         end
      join
      repeat (3) @(negedge clk);
      bfm_abort = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      xfer(8'hF4, 1'b1, 0, 1'b0);

      // Short clock glitch mid-frame plus a busy-time write of 0xAA.
      xfer(8'hF4, 1'b1, 4, 1'b1);

      for (int k = 0; k < 6; k++) begin
         logic [7:0] d;
         bit a;
         int g;
         d = 8'($urandom);
         a = ($urandom_range(0, 3) != 0);
         g = $urandom_range(0, 11);
         xfer(d, a, g, 1'b0);
      end

      repeat (20) @(negedge clk);
      check("ticks_outstanding", exp_tick_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
